// File: rtl/rx_frame_ctrl.sv
// Receive-side frame parser: SYNC, opcode, addr, data, chk (XOR of payload).
// Presents a decoded command with a valid/ready handshake; flags timeouts, bad checksums and overruns.
module rx_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd57288
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_opcode,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, GET_OP, GET_ADDR, GET_DATA, GET_CHK, ISSUE
  } state_t;

  state_t      state_q;
  logic [7:0]  op_q, addr_q, data_q;
  logic [7:0]  cmd_opcode_q, cmd_addr_q, cmd_data_q;
  logic        cmd_valid_q, frame_error_q, overrun_q;
  logic [31:0] cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      op_q          <= 8'h00;
      addr_q        <= 8'h00;
      data_q        <= 8'h00;
      cmd_opcode_q  <= 8'h00;
      cmd_addr_q    <= 8'h00;
      cmd_data_q    <= 8'h00;
      cmd_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      cnt_q         <= 32'd0;
    end else begin
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= 32'd0;
          if (rx_done && rx_data == SYNC_BYTE) state_q <= GET_OP;
        end
        GET_OP, GET_ADDR, GET_DATA, GET_CHK: begin
          // An arriving byte always beats a timeout expiring in the same cycle.
          if (rx_done) begin
            cnt_q <= 32'd0;
            case (state_q)
              GET_OP:   begin op_q   <= rx_data; state_q <= GET_ADDR; end
              GET_ADDR: begin addr_q <= rx_data; state_q <= GET_DATA; end
              GET_DATA: begin data_q <= rx_data; state_q <= GET_CHK;  end
              default: begin
                if (rx_data == (op_q ^ addr_q ^ data_q)) begin
                  cmd_opcode_q <= op_q;
                  cmd_addr_q   <= addr_q;
                  cmd_data_q   <= data_q;
                  cmd_valid_q  <= 1'b1;
                  state_q      <= ISSUE;
                end else begin
                  frame_error_q <= 1'b1;
                  state_q       <= IDLE;
                end
              end
            endcase
          end else if (cnt_q >= TIMEOUT_CYCLES - 32'd1) begin
            frame_error_q <= 1'b1;
            cnt_q         <= 32'd0;
            state_q       <= IDLE;
          end else if (cnt_q != 32'hFFFF_FFFF) begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ISSUE: begin
          cnt_q <= 32'd0;
          // Bytes arriving while a command is pending are dropped.
          if (rx_done) overrun_q <= 1'b1;
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_opcode  = cmd_opcode_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_data    = cmd_data_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: stimulus pushes expected commands into a
// scoreboard queue; a negedge monitor pops/compares on each handshake and counts pulses.
module tb_rx_frame_ctrl;
  localparam logic [31:0] TMO = 32'd40;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid, frame_error, overrun, busy;
  logic [7:0] cmd_opcode, cmd_addr, cmd_data;

  rx_frame_ctrl #(.SYNC_BYTE(8'hAA), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .resetn(resetn), .rx_done(rx_done), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .frame_error(frame_error),
    .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [23:0] exp_q[$];
  int total = 0, passed = 0;
  int ferr_seen = 0, ovr_seen = 0, xfer_seen = 0, vld_cycles = 0;
  int exp_ferr = 0, exp_ovr = 0, exp_xfer = 0;
  logic ferr_prev = 1'b0, ovr_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: sample away from the rising edge.
  always @(negedge clock) begin
    if (resetn) begin
      if (frame_error) begin
        ferr_seen++;
        chk("ferr_width", {31'd0, ferr_prev}, 32'd0);
      end
      if (overrun) begin
        ovr_seen++;
        chk("ovr_width", {31'd0, ovr_prev}, 32'd0);
      end
      if (cmd_valid) begin
        vld_cycles++;
        if (exp_q.size() == 0) begin
          chk("valid_with_empty_sb", {31'd0, cmd_valid}, 32'd0);
        end else begin
          chk("cmd_fields", {8'd0, cmd_opcode, cmd_addr, cmd_data}, {8'd0, exp_q[0]});
          if (cmd_ready) begin
            void'(exp_q.pop_front());
            xfer_seen++;
          end
        end
      end
      ferr_prev = frame_error;
      ovr_prev  = overrun;
    end else begin
      ferr_prev = 1'b0;
      ovr_prev  = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clock); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] ad, input logic [7:0] dt, input logic [7:0] ck);
    send(8'hAA); send(op); send(ad); send(dt); send(ck);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || cmd_valid) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk({name, "_idle_reached"}, {31'd0, busy | cmd_valid}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic end_test(input string name);
    wait_idle(name);
    chk({name, "_ferr_cnt"}, ferr_seen, exp_ferr);
    chk({name, "_ovr_cnt"}, ovr_seen, exp_ovr);
    chk({name, "_xfer_cnt"}, xfer_seen, exp_xfer);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_outputs", {cmd_valid, frame_error, overrun, busy, cmd_opcode, cmd_addr, cmd_data}, 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    // Basic frame with ready high: valid lasts exactly one cycle
    cmd_ready = 1'b1;
    vld_cycles = 0;
    exp_q.push_back(24'h011055); exp_xfer++;
    send_frame(8'h01, 8'h10, 8'h55, 8'h44);
    end_test("basic");
    chk("basic_valid_cycles", vld_cycles, 1);

    // Leading junk ignored; command held under backpressure
    cmd_ready = 1'b0;
    exp_q.push_back(24'h02200F); exp_xfer++;
    send(8'h33);
    send_frame(8'h02, 8'h20, 8'h0F, 8'h2D);
    repeat (10) @(posedge clock);
    #1;
    chk("bp_valid_held", {30'd0, cmd_valid, busy}, 32'd3);
    cmd_ready = 1'b1;
    end_test("backpressure");

    // Checksum mismatch
    exp_ferr++;
    send_frame(8'h01, 8'h10, 8'h55, 8'h45);
    end_test("bad_chk");

    // Timeout after opcode, then a clean frame
    send(8'hAA); send(8'h01);
    exp_ferr++;
    repeat (TMO + 2) @(posedge clock);
    #1;
    chk("tmo_busy_after", {31'd0, busy}, 32'd0);
    exp_q.push_back(24'h030405); exp_xfer++;
    send_frame(8'h03, 8'h04, 8'h05, 8'h02);
    end_test("timeout");

    // Byte arriving exactly on the timeout cycle is accepted
    send(8'hAA);
    repeat (TMO - 1) @(posedge clock);
    #1;
    exp_q.push_back(24'h11AA22); exp_xfer++;
    send(8'h11); send(8'hAA); send(8'h22); send(8'h99);
    end_test("tmo_boundary");

    // Overrun while pending, then overrun on the transfer cycle itself
    cmd_ready = 1'b0;
    exp_q.push_back(24'h123456); exp_xfer++;
    send_frame(8'h12, 8'h34, 8'h56, 8'h70);
    exp_ovr++;
    send(8'h77);
    repeat (2) @(posedge clock);
    #1;
    chk("ovr_busy", {30'd0, cmd_valid, busy}, 32'd3);
    exp_ovr++;
    cmd_ready = 1'b1;
    send(8'h99);
    end_test("overrun");

    // Reset mid-frame discards the partial frame
    send(8'hAA); send(8'h01); send(8'h10);
    resetn = 1'b0;
    #1;
    chk("midrst_outputs", {cmd_valid, frame_error, overrun, busy, cmd_opcode, cmd_addr, cmd_data}, 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    exp_q.push_back(24'h050607); exp_xfer++;
    send_frame(8'h05, 8'h06, 8'h07, 8'h04);
    end_test("after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
